dtw_result_axis_packer: RTL and testbench

- Downstream stage of dtw_core: accepts per-query DTW results (qid, position, minval) on the core's sink interface and buffers them in an internal FIFO.
- Serialises each result as a 3-beat AXI4-Stream packet on M00_AXIS toward the DMA/PS.
- Provides the sink_fifo_full back-pressure that dtw_core observes.
- Tracks overflow/drops for software debug.

---
 rtl/dtw_result_axis_packer.sv | 157 +++++++++++++++
 tb/tb_dtw_result_axis_packer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dtw_result_axis_packer.sv
// dtw_result_axis_packer
// Buffers (qid, position, minval) results from dtw_core in a small FIFO and
// emits each one as a 3-beat AXI4-Stream packet: qid, position, minval(tlast).
// Also reports FIFO fullness back to the core and counts records dropped
// while the FIFO was full.
//
// Stream handshake: a beat transfers on a rising clk edge where
// m00_axis_tvalid && m00_axis_tready. Once tvalid is raised it stays high,
// with tdata/tlast frozen, until that beat transfers.

module dtw_result_axis_packer #(
  parameter int FIFO_DEPTH           = 16,
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int DROP_CNT_WIDTH       = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            sink_fifo_wren,
  input  logic [31:0]                     sink_minval,
  input  logic [31:0]                     sink_position,
  input  logic [31:0]                     sink_qid,
  output logic                            sink_fifo_full,
  output logic                            m00_axis_tvalid,
  input  logic                            m00_axis_tready,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
  output logic [3:0]                      m00_axis_tstrb,
  output logic                            m00_axis_tlast,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            overflow,
  output logic [DROP_CNT_WIDTH-1:0]       drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_CNT = PW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2,
    ST_BEAT2 = 2'd3
  } state_t;

  state_t        state;
  logic [95:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr_next;
  logic [PW-1:0] rd_ptr_next;
  logic [95:0]   head_rec;
  logic [95:0]   out_rec;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push  = sink_fifo_wren && !full;
  // The FSM takes the head record either from IDLE or right after the last
  // beat of the current packet transfers, giving back-to-back packets.
  assign pop   = !empty && ((state == ST_IDLE) ||
                            ((state == ST_BEAT2) && m00_axis_tready));

  assign wr_ptr_next = wr_ptr + PW'(push);
  assign rd_ptr_next = rd_ptr + PW'(pop);
  assign head_rec    = mem[rd_ptr[AW-1:0]];

  assign fifo_count     = wr_ptr - rd_ptr;
  assign m00_axis_tstrb = 4'hF;

  // Record storage: {qid, position, minval}; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {sink_qid, sink_position, sink_minval};
    end
  end

  // FIFO pointers, registered full flag, and drop bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      sink_fifo_full <= 1'b0;
      overflow       <= 1'b0;
      drop_count     <= '0;
    end else begin
      wr_ptr         <= wr_ptr_next;
      rd_ptr         <= rd_ptr_next;
      sink_fifo_full <= ((wr_ptr_next - rd_ptr_next) == DEPTH_CNT);
      if (sink_fifo_wren && full) begin
        overflow <= 1'b1;
        if (drop_count != {DROP_CNT_WIDTH{1'b1}}) begin
          drop_count <= drop_count + DROP_CNT_WIDTH'(1);
        end
      end
    end
  end

  // Packet FSM: loads one record into the output register, then walks beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      out_rec         <= '0;
      m00_axis_tvalid <= 1'b0;
      m00_axis_tdata  <= '0;
      m00_axis_tlast  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            out_rec         <= head_rec;
            m00_axis_tdata  <= head_rec[95:64];
            m00_axis_tlast  <= 1'b0;
            m00_axis_tvalid <= 1'b1;
            state           <= ST_BEAT0;
          end
        end
        ST_BEAT0: begin
          if (m00_axis_tready) begin
            m00_axis_tdata <= out_rec[63:32];
            state          <= ST_BEAT1;
          end
        end
        ST_BEAT1: begin
          if (m00_axis_tready) begin
            m00_axis_tdata <= out_rec[31:0];
            m00_axis_tlast <= 1'b1;
            state          <= ST_BEAT2;
          end
        end
        ST_BEAT2: begin
          if (m00_axis_tready) begin
            if (pop) begin
              out_rec        <= head_rec;
              m00_axis_tdata <= head_rec[95:64];
              m00_axis_tlast <= 1'b0;
              state          <= ST_BEAT0;
            end else begin
              m00_axis_tvalid <= 1'b0;
              m00_axis_tdata  <= '0;
              m00_axis_tlast  <= 1'b0;
              state           <= ST_IDLE;
            end
          end
        end
        default: begin
          m00_axis_tvalid <= 1'b0;
          m00_axis_tlast  <= 1'b0;
          state           <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dtw_result_axis_packer.sv
// Directed bench for dtw_result_axis_packer (FIFO_DEPTH=16, 4-bit drop
// counter). Beats are checked against an expected queue by a monitor;
// directed steps check flags, counts and timing.

module tb_dtw_result_axis_packer;

  logic        clk;
  logic        rst;
  logic        sink_fifo_wren;
  logic [31:0] sink_minval;
  logic [31:0] sink_position;
  logic [31:0] sink_qid;
  logic        sink_fifo_full;
  logic        m00_axis_tvalid;
  logic        m00_axis_tready;
  logic [31:0] m00_axis_tdata;
  logic [3:0]  m00_axis_tstrb;
  logic        m00_axis_tlast;
  logic [4:0]  fifo_count;
  logic        overflow;
  logic [3:0]  drop_count;

  int n_total;
  int n_pass;

  // expected beats: {tlast, tdata}
  logic [32:0] exp_q[$];

  dtw_result_axis_packer #(
    .FIFO_DEPTH(16),
    .C_M_AXIS_TDATA_WIDTH(32),
    .DROP_CNT_WIDTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sink_fifo_wren(sink_fifo_wren),
    .sink_minval(sink_minval),
    .sink_position(sink_position),
    .sink_qid(sink_qid),
    .sink_fifo_full(sink_fifo_full),
    .m00_axis_tvalid(m00_axis_tvalid),
    .m00_axis_tready(m00_axis_tready),
    .m00_axis_tdata(m00_axis_tdata),
    .m00_axis_tstrb(m00_axis_tstrb),
    .m00_axis_tlast(m00_axis_tlast),
    .fifo_count(fifo_count),
    .overflow(overflow),
    .drop_count(drop_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // advance one rising edge, then settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_rec(input logic [31:0] q, input logic [31:0] p, input logic [31:0] m);
    sink_fifo_wren = 1'b1;
    sink_qid       = q;
    sink_position  = p;
    sink_minval    = m;
  endtask

  task automatic idle_in();
    sink_fifo_wren = 1'b0;
    sink_qid       = '0;
    sink_position  = '0;
    sink_minval    = '0;
  endtask

  task automatic expect_rec(input logic [31:0] q, input logic [31:0] p, input logic [31:0] m);
    exp_q.push_back({1'b0, q});
    exp_q.push_back({1'b0, p});
    exp_q.push_back({1'b1, m});
  endtask

  task automatic drain(input int budget);
    for (int c = 0; c < budget; c++) begin
      if (exp_q.size() == 0 && !m00_axis_tvalid) break;
      tick();
    end
    chk("drain_done", 64'((exp_q.size() == 0) && !m00_axis_tvalid), 64'd1);
  endtask

  // ---------------- scoreboard monitor ----------------
  // Samples mid-cycle the beat that transfers on the next rising edge.
  always @(negedge clk) begin
    if (!rst && m00_axis_tvalid && m00_axis_tready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", {31'd0, m00_axis_tlast, m00_axis_tdata}, 64'h1_DEAD_BEEF);
      end else begin
        chk("beat", {31'd0, m00_axis_tlast, m00_axis_tdata}, {31'd0, exp_q[0]});
        void'(exp_q.pop_front());
      end
      chk("tstrb", 64'(m00_axis_tstrb), 64'hF);
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int gaps;
    int tl_cnt;

    n_total = 0;
    n_pass  = 0;
    rst = 1'b1;
    m00_axis_tready = 1'b0;
    idle_in();

    // reset state
    tick(); tick();
    chk("rst_tvalid", 64'(m00_axis_tvalid), 64'd0);
    chk("rst_tdata", 64'(m00_axis_tdata), 64'd0);
    chk("rst_tlast", 64'(m00_axis_tlast), 64'd0);
    chk("rst_tstrb", 64'(m00_axis_tstrb), 64'hF);
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_full", 64'(sink_fifo_full), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);
    rst = 1'b0;
    tick();

    // ---- single record, latency 2 ----
    m00_axis_tready = 1'b1;
    drive_rec(32'h5, 32'h1234, 32'hABCD);
    expect_rec(32'h5, 32'h1234, 32'hABCD);
    tick();
    idle_in();
    chk("single_cnt_n1", 64'(fifo_count), 64'd1);
    chk("single_tvalid_n1", 64'(m00_axis_tvalid), 64'd0);
    tick();
    chk("single_tvalid_n2", 64'(m00_axis_tvalid), 64'd1);
    chk("single_beat0", 64'(m00_axis_tdata), 64'h5);
    chk("single_count_n2", 64'(fifo_count), 64'd0);
    tick();
    chk("single_beat1", {31'd0, m00_axis_tlast, m00_axis_tdata}, 64'h0_0000_1234);
    tick();
    chk("single_beat2", {31'd0, m00_axis_tlast, m00_axis_tdata}, 64'h1_0000_ABCD);
    tick();
    chk("single_done_tvalid", 64'(m00_axis_tvalid), 64'd0);
    chk("single_done_q", 64'(exp_q.size()), 64'd0);

    // ---- backpressure in BEAT1 ----
    drive_rec(32'h7, 32'h77, 32'h777);
    expect_rec(32'h7, 32'h77, 32'h777);
    tick();
    idle_in();
    tick();
    chk("bp_beat0", 64'(m00_axis_tdata), 64'h7);
    tick();
    chk("bp_beat1", 64'(m00_axis_tdata), 64'h77);
    m00_axis_tready = 1'b0;
    gaps = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!m00_axis_tvalid || m00_axis_tdata != 32'h77 || m00_axis_tlast) gaps++;
    end
    chk("bp_hold", 64'(gaps), 64'd0);
    m00_axis_tready = 1'b1;
    tick();
    chk("bp_beat2", {31'd0, m00_axis_tlast, m00_axis_tdata}, 64'h1_0000_0777);
    tick();
    chk("bp_done_tvalid", 64'(m00_axis_tvalid), 64'd0);
    chk("bp_done_q", 64'(exp_q.size()), 64'd0);

    // ---- fill and overflow ----
    m00_axis_tready = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      drive_rec(32'(i), 32'h100 + 32'(i), 32'h1000 + 32'(i));
      if (i <= 17) expect_rec(32'(i), 32'h100 + 32'(i), 32'h1000 + 32'(i));
      if (i == 17) chk("fill_not_full_yet", 64'(sink_fifo_full), 64'd0);
      tick();
    end
    idle_in();
    chk("fill_full", 64'(sink_fifo_full), 64'd1);
    chk("fill_count", 64'(fifo_count), 64'd16);
    chk("fill_ovf", 64'(overflow), 64'd1);
    chk("fill_drop", 64'(drop_count), 64'd1);
    chk("fill_head", {31'd0, m00_axis_tvalid, m00_axis_tdata}, 64'h1_0000_0001);
    m00_axis_tready = 1'b1;
    gaps = 0;
    tl_cnt = 0;
    for (int k = 0; k < 51; k++) begin
      if (!m00_axis_tvalid) gaps++;
      if (m00_axis_tvalid && m00_axis_tlast) tl_cnt++;
      tick();
    end
    chk("fill_gaps", 64'(gaps), 64'd0);
    chk("fill_tlast_cnt", 64'(tl_cnt), 64'd17);
    chk("fill_end_tvalid", 64'(m00_axis_tvalid), 64'd0);
    chk("fill_end_q", 64'(exp_q.size()), 64'd0);
    chk("fill_end_full", 64'(sink_fifo_full), 64'd0);
    chk("fill_end_count", 64'(fifo_count), 64'd0);

    // ---- simultaneous push/pop ----
    drive_rec(32'h21, 32'h2100, 32'h21000);
    expect_rec(32'h21, 32'h2100, 32'h21000);
    tick();
    drive_rec(32'h22, 32'h2200, 32'h22000);
    expect_rec(32'h22, 32'h2200, 32'h22000);
    tick();
    idle_in();
    chk("sim_cnt_p1", 64'(fifo_count), 64'd1);
    tick();
    tick();
    chk("sim_beat2_a", {31'd0, m00_axis_tlast, m00_axis_tdata}, 64'h1_0002_1000);
    chk("sim_cnt_before", 64'(fifo_count), 64'd1);
    drive_rec(32'h23, 32'h2300, 32'h23000);
    expect_rec(32'h23, 32'h2300, 32'h23000);
    tick();
    idle_in();
    chk("sim_cnt_after", 64'(fifo_count), 64'd1);
    chk("sim_b2b", {31'd0, m00_axis_tvalid, m00_axis_tdata}, 64'h1_0000_0022);
    drain(40);
    chk("sim_end_count", 64'(fifo_count), 64'd0);

    // ---- reset mid-packet ----
    m00_axis_tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_rec(32'h40 + 32'(i), 32'h400 + 32'(i), 32'h4000 + 32'(i));
      expect_rec(32'h40 + 32'(i), 32'h400 + 32'(i), 32'h4000 + 32'(i));
      tick();
    end
    idle_in();
    chk("mr_count", 64'(fifo_count), 64'd3);
    m00_axis_tready = 1'b1;
    tick();
    m00_axis_tready = 1'b0;
    chk("mr_in_beat1", {31'd0, m00_axis_tvalid, m00_axis_tdata}, 64'h1_0000_0400);
    chk("mr_ovf_before", 64'(overflow), 64'd1);
    exp_q.delete();
    rst = 1'b1;
    #1;
    chk("mr_tvalid", 64'(m00_axis_tvalid), 64'd0);
    chk("mr_count0", 64'(fifo_count), 64'd0);
    chk("mr_ovf", 64'(overflow), 64'd0);
    chk("mr_drop", 64'(drop_count), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    m00_axis_tready = 1'b1;
    gaps = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (m00_axis_tvalid) gaps++;
    end
    chk("mr_quiet", 64'(gaps), 64'd0);
    drive_rec(32'h55, 32'h550, 32'h5500);
    expect_rec(32'h55, 32'h550, 32'h5500);
    tick();
    idle_in();
    drain(20);

    // ---- drop counter saturation ----
    m00_axis_tready = 1'b0;
    for (int i = 1; i <= 37; i++) begin
      drive_rec(32'h80 + 32'(i), 32'h800 + 32'(i), 32'h8000 + 32'(i));
      if (i <= 17) expect_rec(32'h80 + 32'(i), 32'h800 + 32'(i), 32'h8000 + 32'(i));
      tick();
    end
    idle_in();
    chk("sat_drop", 64'(drop_count), 64'd15);
    chk("sat_ovf", 64'(overflow), 64'd1);
    chk("sat_count", 64'(fifo_count), 64'd16);
    m00_axis_tready = 1'b1;
    drain(120);
    chk("sat_drop_hold", 64'(drop_count), 64'd15);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
